// File: rtl/fp_sched_pkg.sv
// rtl/fp_sched_pkg.sv - shared widths, tag type and sizing helpers for the FP adder scheduler
package fp_sched_pkg;

   localparam int FP_W     = 32;
   localparam int ID_MAX_W = 3;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   typedef struct packed {
      logic                valid;
      logic [ID_MAX_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/fp_res_fifo.sv
// rtl/fp_res_fifo.sv - first-word-fall-through result FIFO with synchronous active-low reset
module fp_res_fifo #(
   parameter int W     = 34,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] wdata,
   output logic         valid,
   input  logic         pop,
   output logic [W-1:0] rdata
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          full;
   logic          do_push;
   logic          do_pop;

   assign valid   = (count != '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & valid;
   assign do_push = push & (~full | do_pop);
   // Empty FIFO presents zeros so the head is clean after reset.
   assign rdata   = valid ? mem[rd_ptr] : '0;

   // Pointer and occupancy bookkeeping; push+pop together keeps occupancy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage array; contents are only meaningful below the occupancy count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/fp_add_sched.sv
// rtl/fp_add_sched.sv - round-robin scheduler sharing one registered FP adder among requesters
module fp_add_sched
   import fp_sched_pkg::*;
#(
   parameter  int NUM_REQ    = 4,
   parameter  int ADD_LAT    = 1,
   parameter  int FIFO_DEPTH = 4,
   localparam int IDW        = id_width(NUM_REQ),
   localparam int CW         = cnt_width(FIFO_DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [FP_W*NUM_REQ-1:0] req_a,
   input  logic [FP_W*NUM_REQ-1:0] req_b,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic [FP_W-1:0]         add_a,
   output logic [FP_W-1:0]         add_b,
   input  logic [FP_W-1:0]         add_out,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [FP_W-1:0]         res_data,
   output logic [IDW-1:0]          res_id,
   output logic [CW-1:0]           inflight
);

   logic [IDW-1:0]      rr_ptr;
   logic [IDW-1:0]      winner;
   logic                found;
   logic                eligible;
   logic                grant;
   logic                pop;
   tag_t                pipe [ADD_LAT+1];
   logic [FP_W+IDW-1:0] fifo_rdata;

   // Credits bound in-flight ops to the FIFO size, so a push never meets a full FIFO.
   assign eligible = (inflight < CW'(FIFO_DEPTH));
   assign grant    = rst_n & eligible & found;
   assign pop      = res_valid & res_ready;

   // Round-robin search beginning just after the previous winner.
   always_comb begin
      int idx;
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = IDW'(idx);
         end
      end
   end

   // One-hot grant, held low during reset and when out of credits.
   always_comb begin
      req_ready = '0;
      if (grant) req_ready[winner] = 1'b1;
   end

   // Capture the winner's operands for the adder and advance the round-robin pointer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         add_a  <= '0;
         add_b  <= '0;
         rr_ptr <= IDW'(NUM_REQ - 1);
      end else if (grant) begin
         add_a  <= req_a[int'(winner)*FP_W +: FP_W];
         add_b  <= req_b[int'(winner)*FP_W +: FP_W];
         rr_ptr <= winner;
      end
   end

   // Tag pipe tracks which requester owns the sum currently moving through the adder.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s <= ADD_LAT; s++) pipe[s] <= '0;
      end else begin
         pipe[0].valid <= grant;
         pipe[0].id    <= ID_MAX_W'(winner);
         for (int s = 1; s <= ADD_LAT; s++) pipe[s] <= pipe[s-1];
      end
   end

   if (IDW < ID_MAX_W) begin : g_id_pad
      logic pad_unused;
      assign pad_unused = ^pipe[ADD_LAT].id[ID_MAX_W-1:IDW];
   end

   // Credit counter: granted-but-not-popped operations.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inflight <= '0;
      end else if (grant && !pop) begin
         inflight <= inflight + CW'(1);
      end else if (!grant && pop) begin
         inflight <= inflight - CW'(1);
      end
   end

   fp_res_fifo #(
      .W     (FP_W + IDW),
      .DEPTH (FIFO_DEPTH)
   ) u_res_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (pipe[ADD_LAT].valid),
      .wdata ({add_out, pipe[ADD_LAT].id[IDW-1:0]}),
      .valid (res_valid),
      .pop   (pop),
      .rdata (fifo_rdata)
   );

   assign res_data = fifo_rdata[FP_W+IDW-1:IDW];
   assign res_id   = fifo_rdata[IDW-1:0];

endmodule

// File: tb/tb_fp_add_sched.sv
// tb/tb_fp_add_sched.sv - self-checking bench for fp_add_sched with a scoreboard model
module tb_fp_add_sched;

   localparam int NR    = 4;
   localparam int DEPTH = 4;
   localparam int LAT   = 3;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [NR-1:0]  req_valid = '0;
   logic [32*NR-1:0] req_a = '0;
   logic [32*NR-1:0] req_b = '0;
   logic [NR-1:0]  req_ready;
   logic [31:0]    add_a;
   logic [31:0]    add_b;
   logic [31:0]    add_out = '0;
   logic           res_valid;
   logic           res_ready = 1'b0;
   logic [31:0]    res_data;
   logic [1:0]     res_id;
   logic [2:0]     inflight;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   fp_add_sched #(.NUM_REQ(NR), .ADD_LAT(1), .FIFO_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_out   (add_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_id    (res_id),
      .inflight  (inflight)
   );

   always #5 clk = ~clk;

   function automatic real sp2r(input logic [31:0] x);
      logic [63:0] d;
      if (x[30:23] == 8'd0) return 0.0;
      d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2sp(input real r);
      logic [63:0] d;
      int e;
      if (r == 0.0) return 32'd0;
      d = $realtobits(r);
      e = int'(d[62:52]) - 1023 + 127;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   function automatic logic [31:0] fpadd(input logic [31:0] a, input logic [31:0] b);
      return r2sp(sp2r(a) + sp2r(b));
   endfunction

   // Adder environment: one registered stage
   always @(posedge clk) add_out <= fpadd(add_a, add_b);

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int          t;
      logic [31:0] d;
      int          id;
   } ent_t;

   ent_t        q[$];
   int          m_inflight = 0;
   int          m_last = NR - 1;

   // Scoreboard model: grant rule, credits, grant-ordered results appearing LAT cycles later
   always @(negedge clk) begin
      logic [NR-1:0] er;
      logic          erv;
      int            w;
      ent_t          e;
      if (!rst_n) begin
         chk("rst_req_ready", 64'(req_ready), 64'd0);
         q.delete();
         m_inflight = 0;
         m_last = NR - 1;
      end else begin
         er = '0;
         w = -1;
         if (m_inflight < DEPTH) begin
            for (int k = 1; k <= NR; k++) begin
               if (w < 0 && req_valid[(m_last + k) % NR]) w = (m_last + k) % NR;
            end
         end
         if (w >= 0) er[w] = 1'b1;
         chk("m_req_ready", 64'(req_ready), 64'(er));
         chk("m_inflight", 64'(inflight), 64'(m_inflight));
         erv = (q.size() > 0) && (cyc >= q[0].t + LAT);
         chk("m_res_valid", 64'(res_valid), 64'(erv));
         if (erv) begin
            chk("m_res_data", 64'(res_data), 64'(q[0].d));
            chk("m_res_id", 64'(res_id), 64'(q[0].id));
            if (res_ready) begin
               void'(q.pop_front());
               m_inflight--;
            end
         end
         if (w >= 0) begin
            e.t  = cyc;
            e.d  = fpadd(req_a[32*w +: 32], req_b[32*w +: 32]);
            e.id = w;
            q.push_back(e);
            m_inflight++;
            m_last = w;
         end
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = '0;
      res_ready = 1'b0;
      nxt();
      rst_n = 1'b1;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
   endtask

   initial begin
      nxt();
      nxt();
      do_reset();

      // Reset state
      chk("rst_add_a", 64'(add_a), 64'd0);
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      chk("rst_res_data", 64'(res_data), 64'd0);
      chk("rst_inflight", 64'(inflight), 64'd0);

      // 1: single request from req0, 1.0 + 2.0
      set_req(0, 32'h3F800000, 32'h40000000);
      req_valid = 4'b0001;
      mid();
      chk("t1_grant", 64'(req_ready), 64'd1);
      nxt();
      req_valid = '0;
      mid();
      chk("t1_rv_c1", 64'(res_valid), 64'd0);
      nxt();
      mid();
      chk("t1_rv_c2", 64'(res_valid), 64'd0);
      nxt();
      mid();
      chk("t1_rv_c3", 64'(res_valid), 64'd1);
      chk("t1_data", 64'(res_data), 64'h40400000);
      chk("t1_id", 64'(res_id), 64'd0);
      nxt();
      res_ready = 1'b1;
      mid();
      nxt();
      res_ready = 1'b0;
      mid();
      chk("t1_empty", 64'(res_valid), 64'd0);
      chk("t1_inflight", 64'(inflight), 64'd0);
      nxt();

      // 2: all requesters valid, consumer always ready
      do_reset();
      res_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         for (int i = 0; i < NR; i++) set_req(i, r2sp(real'(k + i + 1)), r2sp(0.25 * real'(i + 1)));
         req_valid = 4'hF;
         mid();
         chk("t2_rr", 64'(req_ready), 64'(1 << (k % 4)));
         if (k >= 3) begin
            chk("t2_rv", 64'(res_valid), 64'd1);
            chk("t2_id", 64'(res_id), 64'((k - 3) % 4));
         end
         nxt();
      end
      req_valid = '0;
      for (int k = 0; k < 6; k++) nxt();

      // 3: consumer stalled, req1 always valid -> credit limit
      do_reset();
      set_req(1, 32'h3FC00000, 32'h3F800000);
      req_valid = 4'b0010;
      for (int k = 0; k < 9; k++) begin
         mid();
         chk("t3_grant", 64'(req_ready), (k < 4) ? 64'd2 : 64'd0);
         nxt();
      end
      res_ready = 1'b1;
      mid();
      chk("t3_pop_nogrant", 64'(req_ready), 64'd0);
      chk("t3_full", 64'(inflight), 64'd4);
      chk("t3_rv", 64'(res_valid), 64'd1);
      nxt();
      res_ready = 1'b0;
      mid();
      chk("t3_regrant", 64'(req_ready), 64'd2);
      chk("t3_inf3", 64'(inflight), 64'd3);
      nxt();
      mid();
      chk("t3_inf4", 64'(inflight), 64'd4);
      chk("t3_hold", 64'(req_ready), 64'd0);
      nxt();

      // 4: pops and grants together keep credits steady
      res_ready = 1'b1;
      mid();
      chk("t4_inf4", 64'(inflight), 64'd4);
      nxt();
      for (int j = 0; j < 4; j++) begin
         mid();
         chk("t4_inf_steady", 64'(inflight), 64'd3);
         chk("t4_grant", 64'(req_ready), 64'd2);
         nxt();
      end
      req_valid = '0;
      for (int k = 0; k < 8; k++) nxt();

      // 5: reset with ops in flight
      do_reset();
      for (int i = 0; i < NR; i++) set_req(i, r2sp(real'(i + 2)), r2sp(0.5));
      req_valid = 4'hF;
      for (int k = 0; k < 3; k++) begin
         mid();
         nxt();
      end
      rst_n = 1'b0;
      mid();
      nxt();
      rst_n = 1'b1;
      mid();
      chk("t5_rv", 64'(res_valid), 64'd0);
      chk("t5_inf", 64'(inflight), 64'd0);
      chk("t5_first", 64'(req_ready), 64'd1);
      nxt();
      req_valid = '0;
      res_ready = 1'b1;
      for (int k = 5; k <= 10; k++) begin
         mid();
         chk("t5_rv_seq", 64'(res_valid), (k == 7) ? 64'd1 : 64'd0);
         if (k == 7) begin
            chk("t5_id", 64'(res_id), 64'd0);
            chk("t5_data", 64'(res_data), 64'h40200000);
         end
         nxt();
      end

      // 6: head stays stable while consumer stalls
      do_reset();
      set_req(2, 32'h3FC00000, 32'h40100000);
      req_valid = 4'b0100;
      mid();
      nxt();
      req_valid = '0;
      nxt();
      nxt();
      for (int k = 0; k < 5; k++) begin
         mid();
         chk("t6_rv", 64'(res_valid), 64'd1);
         chk("t6_data", 64'(res_data), 64'h40700000);
         chk("t6_id", 64'(res_id), 64'd2);
         nxt();
      end
      res_ready = 1'b1;
      mid();
      nxt();
      res_ready = 1'b0;
      mid();
      chk("t6_empty", 64'(res_valid), 64'd0);
      nxt();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
